// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch step and reset vector
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam int PC_STEP = 4;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small in-order FIFO with flush, used for fetch tags and fetched words
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO can still accept a word when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC, credit-limited imem fetch, response tagging, decoder buffer
// Credit is outstanding fetches plus buffered words; a redirect flushes and drops late responses.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pc_plus4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_W-1:0] pc, tag_pc, new_pc;
   logic [CW-1:0]     outstanding, drop_cnt, fifo_count;
   logic [CW:0]       credit_used;
   logic              issue, rsp, push, pop;
   logic              tag_empty, tag_full, fifo_empty, fifo_full;
   fetch_entry_t      push_e, head_e;

   assign new_pc      = redirect_pc & ~ADDR_W'(3);
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req    = rst_n && !redirect_valid && (credit_used < (CW + 1)'(FIFO_DEPTH));
   assign imem_addr   = pc;
   assign issue       = imem_req && imem_gnt;
   // a response with nothing outstanding is a protocol error and is ignored
   assign rsp         = imem_rvalid && !tag_empty;
   assign push        = rsp && !redirect_valid && (drop_cnt == '0);
   assign pop         = out_ready && !fifo_empty && !redirect_valid;
   assign push_e      = '{instr: imem_rdata, pc: tag_pc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         pc       <= new_pc;
         drop_cnt <= outstanding + CW'(issue) - CW'(rsp);
      end else begin
         if (issue) pc <= pc + ADDR_W'(PC_STEP);
         if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
   end

   // tag queue occupancy doubles as the outstanding-fetch count; never flushed, dropped words still pop it
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W)) u_tag_q (
      .clk(clk), .rst_n(rst_n), .push(issue), .push_data(pc), .pop(rsp), .flush(1'b0),
      .head(tag_pc), .full(tag_full), .empty(tag_empty), .count(outstanding)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_out_q (
      .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_e), .pop(pop), .flush(redirect_valid),
      .head(head_e), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
   );

   assign out_valid    = !fifo_empty;
   assign out_instr    = fifo_empty ? '0 : head_e.instr;
   assign out_pc       = fifo_empty ? '0 : head_e.pc;
   assign out_pc_plus4 = fifo_empty ? '0 : head_e.pc + ADDR_W'(PC_STEP);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rvalid && tag_empty)) else $error("instr_fetch: rvalid with no fetch outstanding");
         assert (!(push && fifo_full && !pop)) else $error("instr_fetch: push into full buffer");
         assert (!(issue && tag_full)) else $error("instr_fetch: issue beyond tag capacity");
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a sequential-PC fetch model
module tb_instr_fetch;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, out_valid, out_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
   );

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } req_t;

   req_t        pend[$];
   int          n_checks = 0, n_fail = 0, cyc = 0, mode = 0, n_pops = 0;
   logic [31:0] exp_issue, exp_out;
   logic        s_req, s_ov, prev_hold, popped;
   logic [31:0] s_addr, s_instr, s_pc, s_pc4, prev_pc, prev_instr, pop_pc, pop_pc4, pop_instr;

   // memory contents: any fixed, address-distinct pattern
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock cycle: mode 0 = gnt tied 1, respond next cycle; 1 = random; 2 = gnt 1, responses held
   task automatic tick();
      logic rsp;
      req_t r;
      rsp = 1'b0;
      if (pend.size() > 0 && pend[0].cyc < cyc)
         rsp = (mode == 0) || (mode == 1 && $urandom_range(0, 1) == 1);
      imem_gnt    = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      imem_rvalid = rsp;
      if (rsp) imem_rdata = word_of(pend[0].addr);
      else     imem_rdata = $urandom;
      @(negedge clk);
      s_req = imem_req; s_addr = imem_addr; s_ov = out_valid;
      s_instr = out_instr; s_pc = out_pc; s_pc4 = out_pc_plus4;
      popped = 1'b0;
      if (prev_hold) begin
         chk("hold_valid", 32'(s_ov), 1);
         chk("hold_pc", s_pc, prev_pc);
         chk("hold_instr", s_instr, prev_instr);
      end
      if (redirect_valid) chk("req_during_redirect", 32'(s_req), 0);
      if (s_req && imem_gnt) begin
         chk("issue_addr", s_addr, exp_issue);
         r.addr = s_addr; r.cyc = cyc;
         pend.push_back(r);
         exp_issue += 32'd4;
         chk("credit_cap", 32'(pend.size() <= 2), 1);
      end
      if (rsp) void'(pend.pop_front());
      if (redirect_valid) begin
         exp_issue = redirect_pc & ~32'h3;
         exp_out   = redirect_pc & ~32'h3;
      end else if (s_ov && out_ready) begin
         popped = 1'b1; n_pops++;
         pop_pc = s_pc; pop_pc4 = s_pc4; pop_instr = s_instr;
         chk("out_pc", s_pc, exp_out);
         chk("out_instr", s_instr, word_of(exp_out));
         chk("out_pc_plus4", s_pc4, exp_out + 32'd4);
         exp_out += 32'd4;
      end
      prev_hold  = s_ov && !out_ready && !redirect_valid;
      prev_pc    = s_pc;
      prev_instr = s_instr;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_pop(input int budget);
      int g;
      g = 0;
      tick();
      while (!popped && g < budget) begin
         tick();
         g++;
      end
   endtask

   initial begin
      int n, g;
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      prev_hold = 1'b0; exp_issue = RST_PC; exp_out = RST_PC;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_pc4", out_pc_plus4, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1; cyc = 0; mode = 0; out_ready = 1'b1;

      // minimum latency: req/gnt cycle 0, rvalid cycle 1, out_valid cycle 2
      tick();
      chk("c0_req", 32'(s_req), 1);
      chk("c0_addr", s_addr, 32'hBFC0_0000);
      chk("c0_valid", 32'(s_ov), 0);
      tick();
      chk("c1_addr", s_addr, 32'hBFC0_0004);
      chk("c1_valid", 32'(s_ov), 0);
      tick();
      chk("c2_valid", 32'(s_ov), 1);
      chk("c2_pc", s_pc, 32'hBFC0_0000);
      chk("c2_pc4", s_pc4, 32'hBFC0_0004);
      repeat (20) tick();

      // decoder stalls: buffer fills to exactly two words, fetch stops
      out_ready = 1'b0;
      repeat (10) tick();
      chk("stall_req", 32'(s_req), 0);
      chk("stall_inflight", 32'(pend.size()), 0);
      chk("stall_valid", 32'(s_ov), 1);
      out_ready = 1'b1; mode = 2; n = n_pops;
      repeat (5) tick();
      chk("stall_drain_count", 32'(n_pops - n), 2);

      // redirect with two fetches in flight: both late words dropped
      chk("pre_redirect_inflight", 32'(pend.size()), 2);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0013;
      tick();
      redirect_valid = 1'b0; mode = 0;
      wait_pop(20);
      chk("redir_pop_seen", 32'(popped), 1);
      chk("redir_first_pc", pop_pc, 32'h8000_0010);

      // redirect in a cycle carrying both gnt and rvalid
      g = 0;
      while (!(pend.size() > 0 && pend[0].cyc < cyc) && g < 20) begin
         tick();
         g++;
      end
      chk("rsp_pending_before_redirect", 32'(pend.size() > 0), 1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
      tick();
      redirect_valid = 1'b0;
      wait_pop(20);
      chk("redir2_pop_seen", 32'(popped), 1);
      chk("redir2_first_pc", pop_pc, 32'h0000_1000);
      chk("redir2_first_instr", pop_instr, word_of(32'h0000_1000));

      // random traffic with occasional redirects
      mode = 1;
      repeat (400) begin
         out_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
         tick();
      end
      redirect_valid = 1'b0; out_ready = 1'b1;

      // address wrap at the top of the space
      mode = 0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF4;
      tick();
      redirect_valid = 1'b0;
      g = 0;
      popped = 1'b0;
      while (!(popped && pop_pc == 32'hFFFF_FFFC) && g < 40) begin
         tick();
         g++;
      end
      chk("wrap_seen", 32'(popped && pop_pc == 32'hFFFF_FFFC), 1);
      chk("wrap_pc4", pop_pc4, 32'h0000_0000);
      wait_pop(20);
      chk("wrap_next_pc", pop_pc, 32'h0000_0000);
      chk("wrap_next_instr", pop_instr, word_of(32'h0000_0000));

      // asynchronous reset with two fetches in flight
      mode = 2;
      g = 0;
      while (pend.size() < 2 && g < 20) begin
         tick();
         g++;
      end
      chk("pre_reset_inflight", 32'(pend.size()), 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_req", 32'(imem_req), 0);
      pend.delete();
      prev_hold = 1'b0; exp_issue = RST_PC; exp_out = RST_PC;
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; mode = 0;
      tick();
      chk("restart_req", 32'(s_req), 1);
      chk("restart_addr", s_addr, RST_PC);
      wait_pop(20);
      chk("restart_pop_pc", pop_pc, RST_PC);
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
